// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared segment encodings for the seven-segment scan display.
//                Patterns are active-low, bit6 = a ... bit0 = g.
//  Revision    : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

endpackage
`default_nettype wire

// File: rtl/seven_seg_hex.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_hex
//  Description : Combinational 4-bit hex nibble to active-low abcdefg decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_hex
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Map each nibble value to its glyph
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan
//  Description : Multiplexed seven-segment driver with slot prescaler, digit
//                scan counter, double-buffered display data, leading-zero
//                blanking and registered, ghost-suppressed outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              segments,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int c_PW = $clog2(REFRESH_DIV);
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(REFRESH_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_MAX   = c_IW'(NUM_DIGITS - 1);

    logic [c_PW-1:0]         r_presc;
    logic [c_IW-1:0]         r_idx;
    logic                    r_pend;
    logic [4*NUM_DIGITS-1:0] r_stage_val;
    logic [NUM_DIGITS-1:0]   r_stage_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [6:0]              r_segments;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_wrap;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_zero_above;
    logic                    w_blank;
    logic [6:0]              w_seg;

    assign w_slot_end   = (r_presc == c_PRESC_MAX);
    assign w_frame_wrap = w_slot_end && (r_idx == c_IDX_MAX);

    // Slot prescaler and digit index counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
            if (w_slot_end)
                r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
        end
    end

    // Double buffer: staging captures every load, display only changes at a
    // frame wrap so a digit never shows data from two different loads
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= 1'b0;
            r_stage_val <= '0;
            r_stage_dp  <= '0;
            r_disp_val  <= '0;
            r_disp_dp   <= '0;
        end else begin
            if (load) begin
                r_stage_val <= value;
                r_stage_dp  <= dp_in;
            end
            if (w_frame_wrap) begin
                // A load landing on the wrap bypasses staging entirely
                if (load) begin
                    r_disp_val <= value;
                    r_disp_dp  <= dp_in;
                end else if (r_pend) begin
                    r_disp_val <= r_stage_val;
                    r_disp_dp  <= r_stage_dp;
                end
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Select the nibble, decimal point and anode for the current digit
    always_comb begin
        w_nibble = 4'h0;
        w_dp_sel = 1'b0;
        w_sel    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_IW'(k)) begin
                w_nibble = r_disp_val[4*k +: 4];
                w_dp_sel = r_disp_dp[k];
                w_sel[k] = 1'b1;
            end
        end
    end

    // Leading-zero blanking: walk down from the top digit while nibbles stay
    // zero; digit 0 is excluded so a zero value still shows one '0'
    always_comb begin
        w_zero_above = 1'b1;
        w_blank      = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above && (r_disp_val[4*k +: 4] == 4'h0);
            if ((r_idx == c_IW'(k)) && w_zero_above)
                w_blank = 1'b1;
        end
        w_blank = w_blank & blank_lz;
    end

    seven_seg_hex u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Output registers; anodes stay off while the prescaler sits at zero so
    // the previous digit's segments never flash on the new anode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_segments   <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_an         <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_segments   <= w_blank ? SEG_BLANK : w_seg;
            r_dp_n       <= w_blank ? 1'b1 : ~w_dp_sel;
            r_an         <= (r_presc == '0) ? '1 : ~w_sel;
            r_frame_tick <= w_frame_wrap;
        end
    end

    assign segments   = r_segments;
    assign dp_n       = r_dp_n;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan
//  Description : Directed self-checking bench for seven_seg_scan with
//                NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  segments;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;
    int n        = 0;   // edges since reset was released

    seven_seg_scan #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .segments   (segments),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    // One full frame starting at a frame boundary. es = {d3,d2,d1,d0} segment
    // patterns expected on the pins, edpn = expected dp_n per digit. Up to two
    // loads can be issued at chosen cycles of the frame (-1 = none).
    task automatic scan_frame(input logic [27:0] es, input logic [3:0] edpn,
                              input int la, input logic [15:0] lav, input logic [3:0] ladp,
                              input int lb, input logic [15:0] lbv, input logic [3:0] lbdp);
        int         s, p, d;
        logic [3:0] exp_an;
        logic       exp_ft;
        for (int i = 0; i < 16; i++) begin
            if (i == la) begin
                value = lav; dp_in = ladp; load = 1'b1;
            end else if (i == lb) begin
                value = lbv; dp_in = lbdp; load = 1'b1;
            end
            step();
            load = 1'b0;
            s = n - 1;
            p = s % 4;
            d = (s / 4) % 4;
            exp_ft = ((n % 16) == 0);
            exp_an = (p == 0) ? 4'b1111 : ~(4'b0001 << d);
            check("frame_tick", {31'd0, frame_tick}, {31'd0, exp_ft});
            check("an", {28'd0, an}, {28'd0, exp_an});
            if (p != 0) begin
                check("segments", {25'd0, segments}, {25'd0, es[7*d +: 7]});
                check("dp_n", {31'd0, dp_n}, {31'd0, edpn[d]});
            end
        end
    endtask

    initial begin
        reset = 1'b1; value = '0; load = 1'b0; dp_in = '0; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_segments", {25'd0, segments}, 32'h7F);
        check("rst_dp_n", {31'd0, dp_n}, 32'd1);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        reset = 1'b0;
        n = 0;

        // Frame 0: empty display; 1234 loaded mid-frame stays off the pins
        scan_frame({7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111,
                   4, 16'h1234, 4'b0000, -1, 16'h0, 4'h0);
        // Frame 1: 1234 (digit0 = 4); 0050 staged mid-frame
        scan_frame({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111,
                   7, 16'h0050, 4'b1010, -1, 16'h0, 4'h0);
        // Frame 2: 0050 with blanking; blanked digit 3 hides its dp
        blank_lz = 1'b1;
        scan_frame({7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b1101,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // Frame 3: 0050 without blanking; AAAA then F00D loaded in-frame
        blank_lz = 1'b0;
        scan_frame({7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b0101,
                   2, 16'hAAAA, 4'b1111, 9, 16'hF00D, 4'b0000);
        // Frame 4: F00D, last load wins; BEEF loaded on the wrap cycle
        scan_frame({7'b0111000, 7'b0000001, 7'b0000001, 7'b1000010}, 4'b1111,
                   15, 16'hBEEF, 4'b0000, -1, 16'h0, 4'h0);
        // Frame 5: BEEF straight from the wrap load; stage 9876
        scan_frame({7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000}, 4'b1111,
                   5, 16'h9876, 4'b0001, -1, 16'h0, 4'h0);
        // Frame 6: 9876 with dp on digit 0; stage 0CA0
        scan_frame({7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000}, 4'b1110,
                   10, 16'h0CA0, 4'b0000, -1, 16'h0, 4'h0);
        // Frame 7: 0CA0 blanked: only digit 3 goes dark; stage 0000
        blank_lz = 1'b1;
        scan_frame({7'b1111111, 7'b0110001, 7'b0001000, 7'b0000001}, 4'b1111,
                   3, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
        // Frame 8: all-zero value blanked, digit 0 still shows '0'
        scan_frame({7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Reset in mid-slot at digit 2, together with a load that must be lost
        blank_lz = 1'b0;
        repeat (9) step();
        reset = 1'b1; load = 1'b1; value = 16'h1111; dp_in = 4'hF;
        step();
        check("mid_rst_an", {28'd0, an}, 32'hF);
        check("mid_rst_segments", {25'd0, segments}, 32'h7F);
        check("mid_rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        check("mid_rst_dp_n", {31'd0, dp_n}, 32'd1);
        reset = 1'b0; load = 1'b0;
        n = 0;
        // Scan resumes from digit 0 showing the cleared display
        scan_frame({7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
